sram_1r1w_param: RTL and testbench

Parametrised single-clock one-write/one-read SRAM macro model for the L1 cache tag and data arrays. It generalises the fixed 19×256 dual-port models: width and depth are configurable, writes have lane masks, the array self-initialises after reset and on flush, and same-address read/write collisions are defined. It sits directly under the L1 cache controller.

---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_1r1w_param_if.sv | 36 +++
 rtl/sram_init_seq.sv | 67 ++++++
 rtl/sram_1r1w_param.sv | 98 +++++++++
 tb/tb_sram_1r1w_param.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and geometry defaults for the parametrised 1R1W SRAM model.
package sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } sram_state_e;

  // Number of mask lanes; the top lane may be narrower than lane.
  function automatic int lanes(input int width, input int lane);
    return (width + lane - 1) / lane;
  endfunction

  localparam int L1_TAG_DATA_WIDTH  = 19;
  localparam int L1_TAG_ADDR_WIDTH  = 8;
  localparam int L1_DATA_DATA_WIDTH = 64;
  localparam int L1_DATA_ADDR_WIDTH = 8;
  localparam int L1_LANE_WIDTH      = 8;

endpackage

// File: rtl/sram_1r1w_param_if.sv
// Request/response bundle between the L1 cache controller (master) and the SRAM (slave).
interface sram_1r1w_param_if
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 19,
  parameter int ADDR_WIDTH = 8,
  parameter int LANE_WIDTH = 8
);

  localparam int NUM_LANES = lanes(DATA_WIDTH, LANE_WIDTH);

  // ready is a level: while it is 0 every we/re is ignored. A read is accepted
  // on any edge with ready=1, re=1, flush=0; rvalid is high for exactly the
  // following cycle and rdata is meaningful only then (it holds otherwise).
  logic                  flush;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NUM_LANES-1:0]  wmask;
  logic                  re;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  ready;

  modport master (
    output flush, we, waddr, wdata, wmask, re, raddr,
    input  rdata, rvalid, ready
  );

  modport slave (
    input  flush, we, waddr, wdata, wmask, re, raddr,
    output rdata, rvalid, ready
  );

endinterface

// File: rtl/sram_init_seq.sv
// INIT/IDLE sequencer: sweeps INIT_VALUE through every word after reset or flush.
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 19,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic [DATA_WIDTH-1:0] init_data,
  output logic                  ready,
  output sram_state_e           state_dbg
);

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    init_we = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we = 1'b1;
        // A flush mid-sweep rewinds; the word at ptr is still written this cycle.
        if (flush) begin
          ptr_d = '0;
        end else if (&ptr_q) begin
          ptr_d   = '0;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      IDLE: begin
        if (flush) begin
          state_d = INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
  end

  assign init_addr = ptr_q;
  assign init_data = INIT_VALUE;
  assign ready     = (state_q == IDLE);
  assign state_dbg = state_q;

endmodule

// File: rtl/sram_1r1w_param.sv
// Parametrised single-clock 1R1W SRAM model with lane masks and self-init.
// Collision read data: write-first when SRAM_BYPASS_EN is defined, read-first otherwise.
module sram_1r1w_param
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 19,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    LANE_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sram_1r1w_param_if.slave         bus,
  output sram_state_e              state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] init_data;
  logic                  ready;

  sram_init_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .ready     (ready),
    .state_dbg (state_dbg)
  );

  // A flush cycle drops any request presented alongside it.
  logic wr_acc, rd_acc, collide;
  assign wr_acc  = ready & bus.we & ~bus.flush;
  assign rd_acc  = ready & bus.re & ~bus.flush;
  assign collide = wr_acc & rd_acc & (bus.waddr == bus.raddr);

  logic [DATA_WIDTH-1:0] bit_mask;
  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_mask
    assign bit_mask[b] = bus.wmask[b / LANE_WIDTH];
  end

  logic [DATA_WIDTH-1:0] old_word, merged_word, rd_word;
  assign old_word    = mem[bus.waddr];
  assign merged_word = (old_word & ~bit_mask) | (bus.wdata & bit_mask);

`ifdef SRAM_BYPASS_EN
  assign rd_word = collide ? merged_word : mem[bus.raddr];
`else
  assign rd_word = mem[bus.raddr];
`endif

  // Array contents are deliberately not reset; the init sweep owns them.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (wr_acc) begin
      mem[bus.waddr] <= merged_word;
    end
  end

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= rd_word;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && collide) begin
      $warning("sram_1r1w_param: read/write collision at addr 0x%0h", bus.raddr);
    end
  end
`endif

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.ready  = ready;

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Directed scoreboard bench for sram_1r1w_param (19x256, 8-bit lanes).
module tb_sram_1r1w_param;
  import sram_pkg::*;

  localparam int DW = 19;
  localparam int AW = 8;
  localparam int LW = 8;

  logic        clk;
  logic        rst_n;
  sram_state_e state_dbg;

  sram_1r1w_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW)) bus ();

  sram_1r1w_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LANE_WIDTH (LW),
    .INIT_VALUE ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_rvalid: got rdata 0x%0h, expected no response at %0t",
                 bus.rdata, $time);
      end else begin
        check("rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 1'b0;
    bus.we    = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.wmask = '0;
    bus.re    = 1'b0;
    bus.raddr = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] m);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d; bus.wmask = m;
    cycle();
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.re = 1'b1; bus.raddr = a;
    exp_q.push_back(exp);
    cycle();
    bus.re = 1'b0;
  endtask

  task automatic wr_rd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [2:0] m, input logic [DW-1:0] exp);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d; bus.wmask = m;
    bus.re = 1'b1; bus.raddr = a;
    exp_q.push_back(exp);
    cycle();
    bus.we = 1'b0; bus.re = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n = 0;
    while (!bus.ready && n < 2000) begin
      cycle();
      n++;
    end
    check(name, 32'(n), 32'(exp_cycles));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_rvalid", 32'(bus.rvalid), 32'd0);
    check("reset_rdata", 32'(bus.rdata), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(INIT));
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("init_sweep_cycles", 256);
    check("idle_state", 32'(state_dbg), 32'(IDLE));

    rd(8'h7F, 19'h00000);

    wr(8'h10, 19'h7FFFF, 3'b111);
    rd(8'h10, 19'h7FFFF);

    // 0x5A5A5 with lanes 0 and 2: bits 7:0 = A5, bits 18:16 = 5, lane 1 stays 00.
    wr(8'h20, 19'h5A5A5, 3'b101);
    rd(8'h20, 19'h500A5);
    wr(8'h20, 19'h7FFFF, 3'b000);
    rd(8'h20, 19'h500A5);
    wr(8'h21, 19'h7FFFF, 3'b010);
    rd(8'h21, 19'h0FF00);

    wr(8'h30, 19'h11111, 3'b111);
`ifdef SRAM_BYPASS_EN
    wr_rd(8'h30, 19'h22222, 3'b111, 19'h22222);
`else
    wr_rd(8'h30, 19'h22222, 3'b111, 19'h11111);
`endif
    rd(8'h30, 19'h22222);
`ifdef SRAM_BYPASS_EN
    wr_rd(8'h30, 19'h000FF, 3'b001, 19'h222FF);
`else
    wr_rd(8'h30, 19'h000FF, 3'b001, 19'h22222);
`endif
    rd(8'h30, 19'h222FF);

    // Back-to-back reads with no gaps
    wr(8'h40, 19'h12345, 3'b111);
    wr(8'h41, 19'h6789A, 3'b111);
    wr(8'h42, 19'h0BCDE, 3'b111);
    rd(8'h40, 19'h12345);
    rd(8'h41, 19'h6789A);
    rd(8'h42, 19'h0BCDE);
    rd(8'h10, 19'h7FFFF);
    cycle();
    check("rvalid_after_idle", 32'(bus.rvalid), 32'd0);
    check("rdata_hold", 32'(bus.rdata), 32'h7FFFF);

    // Flush with a read and write in the same cycle
    wr(8'hFF, 19'h33333, 3'b111);
    rd(8'hFF, 19'h33333);
    drain();
    bus.flush = 1'b1; bus.re = 1'b1; bus.raddr = 8'hFF;
    bus.we = 1'b1; bus.waddr = 8'h10; bus.wdata = 19'h44444; bus.wmask = 3'b111;
    cycle();
    idle_inputs();
    check("flush_rvalid", 32'(bus.rvalid), 32'd0);
    check("flush_ready", 32'(bus.ready), 32'd0);
    check("flush_rdata_hold", 32'(bus.rdata), 32'h33333);
    wait_ready("flush_sweep_cycles", 256);
    rd(8'hFF, 19'h00000);
    rd(8'h10, 19'h00000);
    drain();

    // Reset while a read response is being presented
    bus.re = 1'b1; bus.raddr = 8'h42;
    cycle();
    bus.re = 1'b0;
    check("midread_rvalid_before", 32'(bus.rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midread_rvalid_reset", 32'(bus.rvalid), 32'd0);
    check("midread_ready_reset", 32'(bus.ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset at sweep pointer 100
    repeat (100) cycle();
    check("sweep100_ready", 32'(bus.ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("sweep100_state", 32'(state_dbg), 32'(INIT));
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("sweep_after_reset_cycles", 256);

    // Flush at sweep pointer 200
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    repeat (200) cycle();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    wait_ready("sweep_after_flush200_cycles", 256);
    rd(8'h7F, 19'h00000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
